idex_hazard_ctrl: RTL
=====================

// Module: idex_hazard_ctrl
// PURPOSE
//  Pipeline hazard/sequencing controller for the ID/EX stage register. Detects
//  load-use hazards, branch-taken flushes and multi-cycle EX operations.
//  Drives PC/IF-ID write enables, IF/ID flush, ID/EX write enable and the ID/EX
//  bubble select, which zeroes the WB/M/EX control fields loaded into ID/EX.
//  Sits beside the ID stage. Inputs come from IF/ID decode and the ID/EX outputs.
// PARAMETERS
//  MC_CYCLES  4   EX occupancy of a multi-cycle op in cycles; legal range 2..16
//  CNT_W      16  width of the stall-cycle performance counter
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  id_rs        in   5      Rs of the instruction in ID
//  id_rt        in   5      Rt of the instruction in ID
//  id_uses_rt   in   1      ID instruction reads Rt as a source
//  ex_memread   in   1      MReg memread bit of the instruction in EX (a load)
//  ex_rt        in   5      RtReg of the instruction in EX (load destination)
//  branch_taken in   1      branch resolved taken in EX this cycle
//  mc_start     in   1      ID instruction is a multi-cycle op (mult/div)
//  pc_write     out  1      PC load enable
//  ifid_write   out  1      IF/ID load enable
//  ifid_flush   out  1      IF/ID loads a NOP
//  idex_write   out  1      ID/EX load enable
//  idex_bubble  out  1      ID/EX loads WB=0, M=0, EX=0
//  mc_busy      out  1      registered; multi-cycle op occupying EX
//  stall_cnt    out  CNT_W  registered; saturating count of cycles with pc_write=0
// BEHAVIOUR
//  States: RUN, MC_BUSY. Down-counter mc_cnt is ceil(log2(MC_CYCLES)) bits wide.
//  Reset (async, rst_n=0):
//   state=RUN, mc_cnt=0, mc_busy=0, stall_cnt=0.
//   Outputs: pc_write=0, ifid_write=0, idex_write=0, idex_bubble=1, ifid_flush=0.
//   Pipeline is frozen while reset is asserted.
//   Reset mid multi-cycle op aborts it. The first cycle after release is RUN.
//  hazard = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt))
//  RUN decode, same-cycle combinational outputs, priority top-down:
//   1. branch_taken:
//      ifid_flush=1, idex_bubble=1, pc_write=1, ifid_write=1, idex_write=1.
//      hazard and mc_start are ignored; the ID instruction is on the wrong path.
//   2. hazard:
//      pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1.
//      This is a 1-cycle bubble. The next cycle re-evaluates; the load is then
//      in MEM, so no repeated stall.
//   3. mc_start:
//      Normal advance: all writes=1, bubble=0, flush=0.
//      Next state MC_BUSY, mc_cnt<=MC_CYCLES-1, mc_busy<=1.
//   4. else: normal advance, all writes=1, bubble=0, flush=0.
//  MC_BUSY (op resident in EX):
//   pc_write=0, ifid_write=0, idex_write=0, idex_bubble=0, ifid_flush=0.
//   branch_taken, hazard and mc_start are ignored.
//   Each cycle mc_cnt decrements.
//   When mc_cnt==1 at the clock edge: state<=RUN, mc_busy<=0.
//   Total freeze is exactly MC_CYCLES-1 cycles after the issue cycle.
//  stall_cnt increments on each edge where pc_write==0 and rst_n==1.
//   It saturates at all-ones and does not wrap.
//  A back-to-back mc_start on the first RUN cycle after MC_BUSY is legal and
//   re-enters MC_BUSY with the full count.
//  No X on any output after reset. All registered state updates only on posedge clk.
// TESTING
//  T1 reset:
//   rst_n=0 mid-run -> same cycle pc_write=0, idex_bubble=1, stall_cnt=0.
//   Release -> RUN with all writes=1.
//  T2 load-use:
//   ex_memread=1, ex_rt=5, id_rs=5 -> one cycle pc_write=0, ifid_write=0,
//   idex_bubble=1.
//   Next cycle ex_memread=0 -> normal advance, stall_cnt=1.
//  T3 no false hazard:
//   ex_rt=0, id_rs=0, ex_memread=1 -> no stall.
//   ex_rt=7, id_rt=7, id_uses_rt=0 -> no stall.
//  T4 branch priority:
//   branch_taken=1, hazard=1, mc_start=1 together -> ifid_flush=1, idex_bubble=1,
//   pc_write=1, state stays RUN.
//  T5 multi-cycle:
//   mc_start=1 with MC_CYCLES=4 -> mc_busy high for 3 cycles with all writes=0.
//   Then RUN. stall_cnt +=3.
//   Assert rst_n=0 in cycle 2 -> mc_busy=0 immediately.
//  T6 saturation:
//   CNT_W=4 with 20 stall cycles -> stall_cnt holds at 15.

Source files
------------

// File: rtl/idex_hazard_ctrl.sv
// rtl/idex_hazard_ctrl.sv - ID/EX hazard and sequencing controller
// Resolves load-use stalls, taken-branch flushes and multi-cycle EX occupancy.
module idex_hazard_ctrl #(
    parameter int MC_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    input  logic             mc_start,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_write,
    output logic             idex_bubble,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MCW = (MC_CYCLES > 1) ? $clog2(MC_CYCLES) : 1;
    localparam logic [MCW-1:0] MC_LOAD = MCW'(MC_CYCLES - 1);

    typedef enum logic {RUN, MC_BUSY} state_t;

    state_t             r_state;
    logic [MCW-1:0]     r_mc_cnt;
    logic               r_mc_busy;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_hazard;
    logic               w_mc_issue;

    assign w_hazard = ex_memread && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

    // A branch squashes the ID instruction, so it can neither stall nor issue.
    assign w_mc_issue = (r_state == RUN) && !branch_taken && !w_hazard && mc_start;

    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_write  = 1'b1;
        idex_bubble = 1'b0;
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
            idex_bubble = 1'b1;
        end else if (r_state == MC_BUSY) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_write  = 1'b0;
        end else if (branch_taken) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (w_hazard) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= RUN;
            r_mc_cnt    <= '0;
            r_mc_busy   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            if (!pc_write && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            case (r_state)
                RUN: begin
                    if (w_mc_issue) begin
                        r_state   <= MC_BUSY;
                        r_mc_cnt  <= MC_LOAD;
                        r_mc_busy <= 1'b1;
                    end
                end
                MC_BUSY: begin
                    r_mc_cnt <= r_mc_cnt - MCW'(1);
                    if (r_mc_cnt == MCW'(1)) begin
                        r_state   <= RUN;
                        r_mc_busy <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= RUN;
                    r_mc_busy <= 1'b0;
                end
            endcase
        end
    end

    assign mc_busy   = r_mc_busy;
    assign stall_cnt = r_stall_cnt;

endmodule
